// File: rtl/i2c_bus_monitor.sv
// Passive I2C observer: detects START/STOP, assembles bytes MSB first, reports the 9th (ACK) bit
// and forces the bus idle when SCL stalls for TIMEOUT_CYCLES while a transfer is in progress.
module i2c_bus_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       fastClock,
    input  logic       resetN,
    input  logic       sclIn,
    input  logic       sdaIn,
    output logic       startPulse,
    output logic       stopPulse,
    output logic       busBusy,
    output logic       byteValid,
    output logic [7:0] byteData,
    output logic       isAddress,
    output logic       ackValid,
    output logic       ackBit,
    output logic       timeoutPulse
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        ACK
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic        sclPrev, sdaPrev;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic [6:0]  shift, shift_next;
    logic [15:0] idle_cnt, idle_cnt_next;
    logic        first_byte, first_byte_next;

    logic        start_next, stop_next, busy_next, valid_next;
    logic [7:0]  data_next;
    logic        addr_next, ack_valid_next, ack_bit_next, timeout_next;

    logic        start_det, stop_det, scl_rise, scl_edge;

    // SCL must be stable high across the cycle for SDA movement to count as START/STOP
    assign start_det = sclPrev & sclIn & sdaPrev & ~sdaIn;
    assign stop_det  = sclPrev & sclIn & ~sdaPrev & sdaIn;
    assign scl_rise  = ~sclPrev & sclIn;
    assign scl_edge  = sclPrev ^ sclIn;

    always_ff @(posedge fastClock) begin
        if (!resetN) begin
            state        <= IDLE;
            sclPrev      <= 1'b1;
            sdaPrev      <= 1'b1;
            bit_cnt      <= 3'd0;
            shift        <= 7'd0;
            idle_cnt     <= 16'd0;
            first_byte   <= 1'b0;
            startPulse   <= 1'b0;
            stopPulse    <= 1'b0;
            busBusy      <= 1'b0;
            byteValid    <= 1'b0;
            byteData     <= 8'h00;
            isAddress    <= 1'b0;
            ackValid     <= 1'b0;
            ackBit       <= 1'b1;
            timeoutPulse <= 1'b0;
        end else begin
            state        <= state_next;
            sclPrev      <= sclIn;
            sdaPrev      <= sdaIn;
            bit_cnt      <= bit_cnt_next;
            shift        <= shift_next;
            idle_cnt     <= idle_cnt_next;
            first_byte   <= first_byte_next;
            startPulse   <= start_next;
            stopPulse    <= stop_next;
            busBusy      <= busy_next;
            byteValid    <= valid_next;
            byteData     <= data_next;
            isAddress    <= addr_next;
            ackValid     <= ack_valid_next;
            ackBit       <= ack_bit_next;
            timeoutPulse <= timeout_next;
        end
    end

    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        shift_next      = shift;
        idle_cnt_next   = idle_cnt;
        first_byte_next = first_byte;
        start_next      = 1'b0;
        stop_next       = 1'b0;
        valid_next      = 1'b0;
        data_next       = byteData;
        addr_next       = isAddress;
        ack_valid_next  = 1'b0;
        ack_bit_next    = ackBit;
        timeout_next    = 1'b0;

        if (busBusy) begin
            if (scl_edge) begin
                idle_cnt_next = 16'd0;
            end else if (idle_cnt != TIMEOUT_LAST) begin
                idle_cnt_next = idle_cnt + 16'd1;
            end
        end else begin
            idle_cnt_next = 16'd0;
        end

        // STOP wins over a simultaneous timeout so the bus closes with a single reason
        if (stop_det) begin
            stop_next     = 1'b1;
            state_next    = IDLE;
            bit_cnt_next  = 3'd0;
            idle_cnt_next = 16'd0;
        end else if (start_det) begin
            start_next      = 1'b1;
            state_next      = DATA;
            bit_cnt_next    = 3'd0;
            first_byte_next = 1'b1;
            idle_cnt_next   = 16'd0;
        end else if (busBusy && !scl_edge && idle_cnt == TIMEOUT_LAST) begin
            timeout_next  = 1'b1;
            state_next    = IDLE;
            bit_cnt_next  = 3'd0;
            idle_cnt_next = 16'd0;
        end else if (scl_rise) begin
            case (state)
                DATA: begin
                    shift_next = {shift[5:0], sdaIn};
                    if (bit_cnt == 3'd7) begin
                        valid_next      = 1'b1;
                        data_next       = {shift, sdaIn};
                        addr_next       = first_byte;
                        first_byte_next = 1'b0;
                        state_next      = ACK;
                        bit_cnt_next    = 3'd0;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
                ACK: begin
                    ack_valid_next = 1'b1;
                    ack_bit_next   = sdaIn;
                    state_next     = DATA;
                end
                default: begin
                end
            endcase
        end

        busy_next = (state_next != IDLE);
    end

endmodule
